// File: rtl/pool_result_collector.sv
// Captures one frame of pooled accelerator samples into a buffer and serves
// host reads once complete. Define POOL_COLLECTOR_MAX_TRACK_EN to track the frame maximum.
module pool_result_collector #(
    parameter  int N     = 16,
    parameter  int OUT_W = 2,
    localparam int DEPTH = OUT_W * OUT_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic          din_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          frame_done,
    output logic          overflow,
    output logic [AW:0]   count,
    output logic [N-1:0]  frame_max
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    state_t        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [N-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          addr_ok;

    logic [N-1:0]  mem [DEPTH];

    assign wr_addr = count_q[AW-1:0];
    assign addr_ok = ({1'b0, rd_addr} < DEPTH_C);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;

        // Read path looks only at the current state, so a same-cycle start
        // in DONE still returns the pre-restart contents.
        if (state_q == DONE && rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = addr_ok ? mem[rd_addr] : '0;
        end

        case (state_q)
            COLLECT: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (din_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == DEPTH_C - 1'b1)
                        state_d = DONE;
                end
            end
            IDLE, DONE: begin
                if (start) begin
                    state_d    = COLLECT;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (din_valid) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= din;
    end

`ifdef POOL_COLLECTOR_MAX_TRACK_EN
    logic [N-1:0] frame_max_q, frame_max_d;

    always_comb begin
        frame_max_d = frame_max_q;
        if (start)
            frame_max_d = '0;
        else if (wr_en && din > frame_max_q)
            frame_max_d = din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            frame_max_q <= '0;
        else
            frame_max_q <= frame_max_d;
    end

    assign frame_max = frame_max_q;
`else
    assign frame_max = '0;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q == COLLECT);
    assign frame_done = (state_q == DONE);
    assign overflow   = overflow_q;
    assign count      = count_q;

endmodule

// File: tb/tb_pool_result_collector.sv
// Directed bench for pool_result_collector: a 2x2 instance for the main flow
// and a 3x3 instance for out-of-range reads on a non-power-of-two depth.
module tb_pool_result_collector;

    localparam int N   = 16;
    localparam int AW  = 2;
    localparam int AW3 = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  din;
    logic          din_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [AW3-1:0] rd_addr3;

    logic [N-1:0]  rd_data, rd_data3;
    logic          rd_valid, rd_valid3;
    logic          busy, busy3;
    logic          frame_done, frame_done3;
    logic          overflow, overflow3;
    logic [AW:0]   count;
    logic [AW3:0]  count3;
    logic [N-1:0]  frame_max, frame_max3;

    int checks   = 0;
    int failures = 0;

    pool_result_collector #(.N(N), .OUT_W(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .count(count), .frame_max(frame_max)
    );

    pool_result_collector #(.N(N), .OUT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .rd_en(rd_en), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .busy(busy3), .frame_done(frame_done3), .overflow(overflow3),
        .count(count3), .frame_max(frame_max3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] v);
        din       = v;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [N-1:0] frame_a [4];
    logic [31:0]  exp_max;

    initial begin
        frame_a[0] = 16'h0010; frame_a[1] = 16'h0020;
        frame_a[2] = 16'h0005; frame_a[3] = 16'h0030;

        rst = 1'b0; start = 1'b0; din = '0; din_valid = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_addr3 = '0;
        tick(); tick();

        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_done",      32'(frame_done), 32'd0);
        chk("rst_overflow",  32'(overflow), 32'd0);
        chk("rst_count",     32'(count), 32'd0);
        chk("rst_rd_valid",  32'(rd_valid), 32'd0);
        chk("rst_rd_data",   32'(rd_data), 32'd0);
        chk("rst_frame_max", 32'(frame_max), 32'd0);

        rst = 1'b1;
        tick();

        // start in IDLE with a same-cycle sample: sample is dropped
        start = 1'b1; din = 16'h00AA; din_valid = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0;
        chk("arm_busy",     32'(busy), 32'd1);
        chk("arm_count",    32'(count), 32'd0);
        chk("arm_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 4; i++) push(frame_a[i]);
        chk("f1_count", 32'(count), 32'd4);
        chk("f1_done",  32'(frame_done), 32'd1);
        chk("f1_busy",  32'(busy), 32'd0);
`ifdef POOL_COLLECTOR_MAX_TRACK_EN
        exp_max = 32'h0030;
`else
        exp_max = 32'h0000;
`endif
        chk("f1_frame_max", 32'(frame_max), exp_max);

        // back-to-back reads, one per clock
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = AW'(i);
            tick();
            chk($sformatf("rd%0d_valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("rd%0d_data", i),  32'(rd_data), 32'(frame_a[i]));
        end
        rd_en = 1'b0;
        tick();
        chk("rd_idle_valid", 32'(rd_valid), 32'd0);
        chk("rd_idle_hold",  32'(rd_data), 32'h0030);

        // late sample in DONE
        push(16'h0099);
        chk("ovf_set",  32'(overflow), 32'd1);
        chk("ovf_done", 32'(frame_done), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        rd_en = 1'b0;
        chk("ovf_buf0", 32'(rd_data), 32'h0010);

        // start and read in the same DONE cycle
        start = 1'b1; rd_en = 1'b1; rd_addr = 2'd3;
        tick();
        start = 1'b0; rd_en = 1'b0;
        chk("rs_valid",    32'(rd_valid), 32'd1);
        chk("rs_data",     32'(rd_data), 32'h0030);
        chk("rs_busy",     32'(busy), 32'd1);
        chk("rs_overflow", 32'(overflow), 32'd0);
        chk("rs_count",    32'(count), 32'd0);

        rd_en = 1'b1; rd_addr = 2'd1;
        tick();
        rd_en = 1'b0;
        chk("col_rd_valid", 32'(rd_valid), 32'd0);
        chk("col_rd_hold",  32'(rd_data), 32'h0030);

        push(16'h0101);
        push(16'h0202);
        chk("mid_count", 32'(count), 32'd2);
        start = 1'b1; din = 16'h0F0F; din_valid = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0;
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_busy",  32'(busy), 32'd1);

        for (int i = 1; i <= 4; i++) push(N'(i));
        chk("f2_done", 32'(frame_done), 32'd1);
`ifdef POOL_COLLECTOR_MAX_TRACK_EN
        exp_max = 32'h0004;
`else
        exp_max = 32'h0000;
`endif
        chk("f2_frame_max", 32'(frame_max), exp_max);
        rd_en = 1'b1; rd_addr = 2'd0;
        tick();
        rd_en = 1'b0;
        chk("f2_buf0", 32'(rd_data), 32'h0001);

        // 3x3 frame for out-of-range addressing
        pulse_start();
        for (int i = 0; i < 9; i++) push(N'(16'h0100 + i));
        chk("d9_done",  32'(frame_done3), 32'd1);
        chk("d9_count", 32'(count3), 32'd9);
        rd_en = 1'b1; rd_addr = 2'd2;
        rd_addr3 = 4'd8;
        tick();
        chk("d9_rd8_valid", 32'(rd_valid3), 32'd1);
        chk("d9_rd8_data",  32'(rd_data3), 32'h0108);
        rd_addr3 = 4'd9;
        tick();
        chk("d9_rd9_valid", 32'(rd_valid3), 32'd1);
        chk("d9_rd9_data",  32'(rd_data3), 32'h0000);
        rd_addr3 = 4'd4;
        tick();
        chk("d9_rd4_data",  32'(rd_data3), 32'h0104);
        rd_addr3 = 4'd15;
        tick();
        rd_en = 1'b0;
        chk("d9_rd15_data", 32'(rd_data3), 32'h0000);
        chk("d4_rd2_data",  32'(rd_data), 32'h0102);

        // asynchronous reset partway through a frame
        pulse_start();
        push(16'h0001); push(16'h0002); push(16'h0003);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        chk("arst_count",    32'(count), 32'd0);
        chk("arst_busy",     32'(busy), 32'd0);
        chk("arst_rd_data",  32'(rd_data), 32'd0);
        chk("arst_frame_max", 32'(frame_max), 32'd0);
        #1;
        rst = 1'b1;
        push(16'h0055);
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        chk("post_rst_idle_done", 32'(frame_done), 32'd0);
        chk("post_rst_count",     32'(count), 32'd0);

        pulse_start();
        push(16'h000A); push(16'h000B); push(16'h000C); push(16'h000D);
        chk("f3_done", 32'(frame_done), 32'd1);
        rd_en = 1'b1; rd_addr = 2'd2;
        tick();
        rd_en = 1'b0;
        chk("f3_rd2_valid", 32'(rd_valid), 32'd1);
        chk("f3_rd2_data",  32'(rd_data), 32'h000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
